// File: rtl/pipe_stage_skid.sv
// Two-entry (main + skid) valid/ready pipeline register.
// Registered upstream ready, flush with clear mask, stall counter.
module pipe_stage_skid #(
  parameter int                   PAYLOAD_W = 32,
  parameter logic [PAYLOAD_W-1:0] CLR_MASK  = {PAYLOAD_W{1'b1}},
  parameter int                   CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [PAYLOAD_W-1:0] in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [PAYLOAD_W-1:0] out_data,
  input  logic                 cnt_clr,
  output logic [CNT_W-1:0]     stall_cnt
);

  // bit0 = main entry valid, bit1 = skid entry valid
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    FULL  = 2'b11
  } state_e;

  state_e               state_q;
  logic [PAYLOAD_W-1:0] m_data_q;
  logic [PAYLOAD_W-1:0] s_data_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [CNT_W-1:0]     cnt_d;

  logic m_valid;
  logic s_valid;
  logic in_fire;
  logic out_fire;
  logic stall;

  assign m_valid  = state_q[0];
  assign s_valid  = state_q[1];
  assign in_ready = ~s_valid;
  assign in_fire  = in_valid & in_ready;
  assign out_fire = m_valid & out_ready;
  assign stall    = m_valid & ~out_ready;

  assign out_valid = m_valid;
  assign out_data  = m_data_q;
  assign stall_cnt = cnt_q;

  // Occupancy FSM and payload storage; data only loads on in_fire
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= EMPTY;
      m_data_q <= '0;
      s_data_q <= '0;
    end else if (flush) begin
      state_q  <= EMPTY;
      m_data_q <= m_data_q & ~CLR_MASK;
      s_data_q <= s_data_q & ~CLR_MASK;
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_fire) begin
            state_q  <= ONE;
            m_data_q <= in_data;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            m_data_q <= in_data;
          end else if (in_fire) begin
            state_q  <= FULL;
            s_data_q <= in_data;
          end else if (out_fire) begin
            state_q <= EMPTY;
          end
        end
        FULL: begin
          if (out_fire) begin
            state_q  <= ONE;
            m_data_q <= s_data_q;
          end
        end
        default: state_q <= EMPTY;
      endcase
    end
  end

  // Saturating backpressure counter; clear wins over increment
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr)
      cnt_d = '0;
    else if (stall && !(&cnt_q))
      cnt_d = cnt_q + 1'b1;
  end

  // Counter register; flush leaves it alone
  always_ff @(posedge clk) begin
    if (rst)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed-vector bench for pipe_stage_skid.
// Small config: 16-bit payload, mask 16'hFF00, 3-bit counter.
module tb_pipe_stage_skid;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready;
  logic [15:0] in_data, out_data;
  logic        out_valid, out_ready, cnt_clr;
  logic [2:0]  stall_cnt;

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  pipe_stage_skid #(
    .PAYLOAD_W(16),
    .CLR_MASK (16'hFF00),
    .CNT_W    (3)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .cnt_clr  (cnt_clr),
    .stall_cnt(stall_cnt)
  );

  typedef struct {
    logic        rst, flush, iv;
    logic [15:0] d;
    logic        ordy, clr;
    logic        e_ov, e_ir;
    logic [15:0] e_od;
    logic [2:0]  e_cnt;
  } vec_t;

  vec_t tv[$];

  task automatic add(input logic r, f, v, input logic [15:0] d,
                     input logic o, c, eov, eir,
                     input logic [15:0] eod, input logic [2:0] ec);
    vec_t t;
    t.rst = r; t.flush = f; t.iv = v; t.d = d;
    t.ordy = o; t.clr = c;
    t.e_ov = eov; t.e_ir = eir; t.e_od = eod; t.e_cnt = ec;
    tv.push_back(t);
  endtask

  task automatic chk(input string nm, input int idx,
                     input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s step %0d: got %h expected %h", nm, idx, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int sent, recv, cyc;
    logic acc, del, held;
    logic [15:0] dv, prev;

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0;
    out_ready = 1'b0; cnt_clr = 1'b0;

    // r f v  data      o c  ov ir  od        cnt
    // reset
    add(1,0,0,16'h0000,  0,0, 0,1, 16'h0000, 0);
    // streaming
    add(0,0,1,16'h0011,  1,0, 1,1, 16'h0011, 0);
    add(0,0,1,16'h0022,  1,0, 1,1, 16'h0022, 0);
    add(0,0,1,16'h0033,  1,0, 1,1, 16'h0033, 0);
    add(0,0,0,16'hxxxx,  1,0, 0,1, 16'h0033, 0);
    // backpressure into FULL, then drain
    add(0,0,1,16'h00A1,  0,0, 1,1, 16'h00A1, 0);
    add(0,0,1,16'h00A2,  0,0, 1,0, 16'h00A1, 1);
    add(0,0,1,16'hBEEF,  0,0, 1,0, 16'h00A1, 2);
    add(0,0,0,16'hxxxx,  1,0, 1,1, 16'h00A2, 2);
    add(0,0,0,16'hxxxx,  1,0, 0,1, 16'h00A2, 2);
    add(0,0,0,16'hxxxx,  0,1, 0,1, 16'h00A2, 0);
    // simultaneous fire in ONE
    for (int k = 1; k <= 8; k++)
      add(0,0,1,16'(16'h0101*k), 1,0, 1,1, 16'(16'h0101*k), 0);
    add(0,0,0,16'hxxxx,  1,0, 0,1, 16'h0808, 0);
    // flush with mask from FULL
    add(0,0,1,16'h1234,  0,0, 1,1, 16'h1234, 0);
    add(0,0,1,16'h5678,  0,0, 1,0, 16'h1234, 1);
    add(0,1,1,16'h9999,  0,0, 0,1, 16'h0034, 2);
    add(0,0,0,16'hxxxx,  1,0, 0,1, 16'h0034, 2);
    // reset mid-operation with flush and in_valid
    add(0,0,1,16'hAAAA,  0,0, 1,1, 16'hAAAA, 2);
    add(0,0,1,16'hBBBB,  0,0, 1,0, 16'hAAAA, 3);
    add(0,0,0,16'hxxxx,  0,0, 1,0, 16'hAAAA, 4);
    add(0,0,0,16'hxxxx,  0,0, 1,0, 16'hAAAA, 5);
    add(1,1,1,16'hCCCC,  0,0, 0,1, 16'h0000, 0);
    // counter saturation
    add(0,0,1,16'h0F0F,  0,0, 1,1, 16'h0F0F, 0);
    for (int k = 1; k <= 10; k++)
      add(0,0,0,16'hxxxx, 0,0, 1,1, 16'h0F0F, 3'((k > 7) ? 7 : k));
    add(0,0,0,16'hxxxx,  0,1, 1,1, 16'h0F0F, 0);
    add(0,0,0,16'hxxxx,  0,0, 1,1, 16'h0F0F, 1);
    add(0,1,0,16'hxxxx,  0,0, 0,1, 16'h000F, 2);
    add(0,0,0,16'hxxxx,  1,0, 0,1, 16'h000F, 2);

    foreach (tv[i]) begin
      rst = tv[i].rst; flush = tv[i].flush;
      in_valid = tv[i].iv; in_data = tv[i].d;
      out_ready = tv[i].ordy; cnt_clr = tv[i].clr;
      tick();
      chk("out_valid", i, 32'(out_valid), 32'(tv[i].e_ov));
      chk("in_ready",  i, 32'(in_ready),  32'(tv[i].e_ir));
      chk("out_data",  i, 32'(out_data),  32'(tv[i].e_od));
      chk("stall_cnt", i, 32'(stall_cnt), 32'(tv[i].e_cnt));
    end

    // ordered stream under periodic backpressure
    rst = 1'b1; flush = 1'b0; cnt_clr = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0;
    tick();
    rst = 1'b0;
    sent = 0; recv = 0; held = 1'b0; prev = '0;
    for (cyc = 0; cyc < 100 && recv < 6; cyc++) begin
      in_valid  = (sent < 6);
      in_data   = 16'(16'h0100 + sent);
      out_ready = (cyc % 3) != 0;
      #1;
      if (held)
        chk("hold_stable", cyc, 32'(out_data), 32'(prev));
      acc  = in_valid & in_ready;
      del  = out_valid & out_ready;
      dv   = out_data;
      held = out_valid & ~out_ready;
      prev = out_data;
      tick();
      if (acc) sent++;
      if (del) begin
        chk("order", cyc, 32'(dv), 32'(16'h0100 + recv));
        recv++;
      end
    end
    chk("stream_done", cyc, 32'(recv), 32'd6);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
- Parametrised successor to the fixed-field inter-stage pipeline register.
- Carries one generic payload word between CPU pipeline stages using a valid/ready handshake instead of a global enable.
- Holds two entries (main + skid), so upstream ready is fully registered and throughput is 1 word/cycle under backpressure.
- Supports flush with per-bit clear masking (bubble insertion) and a saturating stall counter for performance analysis.

Parameters:
- PAYLOAD_W, 32, payload width in bits (sum of stage fields: PC, IR, control word, register indices, operands).
- CLR_MASK, {PAYLOAD_W{1'b1}}, bit=1 means the payload bit is zeroed on flush; bit=0 means it is retained.
- CNT_W, 16, stall counter width.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- flush  input  1  synchronous pipeline flush (branch/jump kill).
- in_valid  input  1  upstream word valid.
- in_ready  output  1  block can accept a word this cycle; registered.
- in_data  input  PAYLOAD_W  upstream payload.
- out_valid  output  1  downstream word valid.
- out_ready  input  1  downstream accepts a word this cycle.
- out_data  output  PAYLOAD_W  downstream payload.
- cnt_clr  input  1  synchronous clear of stall_cnt.
- stall_cnt  output  CNT_W  saturating count of backpressure cycles.

Behaviour:
- Reset (rst=1 at posedge): m_valid=0, s_valid=0, m_data=0, s_data=0, in_ready=1 (registered as ~s_valid of the reset state), out_valid=0, out_data=0, stall_cnt=0. rst overrides flush and all other inputs.
- in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- Outputs: out_valid = m_valid; out_data = m_data; in_ready = ~s_valid (a function of registers only).
- States:
  - EMPTY: m=0, s=0.
  - ONE: m=1, s=0.
  - FULL: m=1, s=1.
- Transitions (no flush):
  - EMPTY + in_fire -> ONE; m_data <= in_data.
  - ONE + in_fire + out_fire -> ONE; m_data <= in_data.
  - ONE + in_fire + ~out_ready -> FULL; s_data <= in_data.
  - ONE + out_fire + ~in_fire -> EMPTY.
  - FULL + out_fire -> ONE; m_data <= s_data. No input is accepted because in_ready=0.
  - FULL + ~out_ready -> FULL; contents held.
  - All other combinations -> hold.
- Latency: 1 cycle from in_fire to out_valid when EMPTY. Order is strictly FIFO. No word is dropped or duplicated.
- Held data is stable: while out_valid & ~out_ready, out_data must not change.
- Flush (flush=1, rst=0):
  - Next state is EMPTY.
  - m_data <= m_data & ~CLR_MASK; s_data <= s_data & ~CLR_MASK.
  - A word presented on the flush cycle is dropped, even if in_fire.
  - out_fire on the flush cycle still counts as delivered downstream.
  - With CLR_MASK all-ones, out_data = 0 after a flush.
- stall_cnt:
  - Increments by 1 each cycle with m_valid & ~out_ready.
  - Saturates at all-ones; no wrap.
  - cnt_clr sets it to 0 and has priority over the increment.
  - flush does not clear it.
- An unknown value on in_data while in_valid=0 must not propagate into state.

Test Plan:
- Streaming: rst, then in_valid=1 with data 0x11,0x22,0x33 on consecutive cycles and out_ready=1 -> out_valid from cycle 1, out_data 0x11,0x22,0x33 on consecutive cycles, in_ready constantly 1, stall_cnt=0.
- Backpressure: send 0xA1 and 0xA2 with out_ready=0 -> in_ready=0 after the second word, out_data holds 0xA1. Raise out_ready for 2 cycles -> 0xA1 then 0xA2 are delivered, in_ready returns to 1, stall_cnt=2 (if held for 2 cycles before release).
- Flush with mask: PAYLOAD_W=16, CLR_MASK=16'hFF00, state FULL holding 0x1234/0x5678, then flush=1 with in_valid=1 data 0x9999 -> next cycle out_valid=0, m_data=0x0034, in_ready=1, 0x9999 never appears.
- Reset mid-operation: state FULL with stall_cnt=5, rst=1 together with flush=1 and in_valid=1 -> all outputs 0, in_ready=1, stall_cnt=0 the next cycle.
- Counter saturation: CNT_W=3, out_valid held with out_ready=0 for 10 cycles -> stall_cnt stops at 7. cnt_clr=1 on a stall cycle -> stall_cnt=0.
- Simultaneous fire in ONE: in_fire and out_fire every cycle for 8 words -> state stays ONE, s_valid never set, output order matches input.
